// File: rtl/nav_button_conditioner.sv
// nav_button_conditioner: synchronise, debounce, pulse and auto-repeat
// the two palette-navigation buttons, with a mutual-exclusion lock.
module nav_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic fwd_raw,
  input  logic bwd_raw,
  output logic forward,
  output logic backward,
  output logic fwd_held,
  output logic bwd_held
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD)
                      ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REPEAT
  } state_t;

  // index 0 is the forward button, index 1 the backward button
  logic [1:0]    raw;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    lvl;
  logic [1:0]    lvl_d;
  logic [1:0]    flip;
  logic [1:0]    fall;
  logic [1:0]    pend;
  logic [1:0]    sup;
  logic [1:0]    pulse;
  logic [DW-1:0] dcnt [2];
  logic [RW-1:0] rcnt [2];
  state_t        state [2];
  logic          lock;

  assign raw = {bwd_raw, fwd_raw};

  always_comb begin
    flip = '0;
    fall = '0;
    pend = '0;
    for (int i = 0; i < 2; i++) begin
      flip[i] = (s2[i] != lvl[i]) && (dcnt[i] == DB_LAST);
      fall[i] = flip[i] & lvl[i];
      if (!lock && !fall[i]) begin
        case (state[i])
          IDLE:    pend[i] = lvl[i] & ~lvl_d[i];
          WAIT:    pend[i] = REPEAT_EN && (rcnt[i] == DLY_LAST);
          REPEAT:  pend[i] = (rcnt[i] == PER_LAST);
          default: pend[i] = 1'b0;
        endcase
      end
    end
  end

  // a pending pulse loses whenever the other button is already down
  assign sup   = pend & {lvl[0], lvl[1]};
  assign pulse = pend & ~sup;

  assign fwd_held = lvl[0];
  assign bwd_held = lvl[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= '0;
      s2       <= '0;
      lvl      <= '0;
      lvl_d    <= '0;
      lock     <= 1'b0;
      forward  <= 1'b0;
      backward <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        dcnt[i]  <= '0;
        rcnt[i]  <= '0;
        state[i] <= IDLE;
      end
    end else begin
      s1       <= raw;
      s2       <= s1;
      lvl_d    <= lvl;
      lock     <= lock ? |lvl : |sup;
      forward  <= pulse[0];
      backward <= pulse[1];
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != lvl[i]) begin
          if (flip[i]) begin
            lvl[i]  <= ~lvl[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + DW'(1);
          end
        end else begin
          dcnt[i] <= '0;
        end

        if (lock || |sup || fall[i]) begin
          state[i] <= IDLE;
          rcnt[i]  <= '0;
        end else begin
          case (state[i])
            IDLE: begin
              rcnt[i] <= '0;
              if (pend[i]) state[i] <= WAIT;
            end
            WAIT: begin
              if (pend[i]) begin
                state[i] <= REPEAT;
                rcnt[i]  <= '0;
              end else if (REPEAT_EN) begin
                rcnt[i] <= rcnt[i] + RW'(1);
              end
            end
            REPEAT: begin
              if (pend[i]) rcnt[i] <= '0;
              else         rcnt[i] <= rcnt[i] + RW'(1);
            end
            default: begin
              state[i] <= IDLE;
              rcnt[i]  <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nav_button_conditioner.sv
// tb_nav_button_conditioner: directed and random stimulus against an
// event-schedule reference model, for repeat-enabled and one-shot builds.
module tb_nav_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic reset;
  logic fwd_raw;
  logic bwd_raw;
  logic forward_a, backward_a, fwd_held_a, bwd_held_a;
  logic forward_b, backward_b, fwd_held_b, bwd_held_b;

  always #5 clk = ~clk;

  nav_button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1)
  ) u_rep (
    .clk(clk), .reset(reset),
    .fwd_raw(fwd_raw), .bwd_raw(bwd_raw),
    .forward(forward_a), .backward(backward_a),
    .fwd_held(fwd_held_a), .bwd_held(bwd_held_a)
  );

  nav_button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .REPEAT_EN(1'b0)
  ) u_one (
    .clk(clk), .reset(reset),
    .fwd_raw(fwd_raw), .bwd_raw(bwd_raw),
    .forward(forward_b), .backward(backward_b),
    .fwd_held(fwd_held_b), .bwd_held(bwd_held_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at edge %0d", tag, got, exp, ec - 1);
    end
  endtask

  // reference model: raw history, settled levels, press schedule
  bit raw_h [2][0:8191];
  int rst_e = 0;
  int ec = 0;
  bit lv [2];
  int streak [2];
  int rise_e [2][2];
  bit killed [2][2];
  bit lk [2];
  bit expp [2][2];

  function automatic void model_edge(bit f, bit b, bit r);
    bit in_raw [2];
    bit nl [2];
    bit fl [2];
    bit rs [2];
    bit pend [2];
    bit sup [2];
    bit sync;
    bit any_sup;
    bit hit;
    int k;
    in_raw[0] = f;
    in_raw[1] = b;
    for (int bt = 0; bt < 2; bt++) raw_h[bt][ec] = in_raw[bt];
    if (r) begin
      rst_e = ec;
      for (int bt = 0; bt < 2; bt++) begin
        lv[bt] = 0;
        streak[bt] = 0;
        for (int m = 0; m < 2; m++) begin
          killed[m][bt] = 1;
          expp[m][bt] = 0;
          rise_e[m][bt] = -100;
        end
      end
      lk[0] = 0;
      lk[1] = 0;
      ec++;
      return;
    end
    for (int bt = 0; bt < 2; bt++) begin
      sync = (ec >= 2 && ec - 2 > rst_e) ? raw_h[bt][ec-2] : 1'b0;
      nl[bt] = lv[bt];
      if (sync != lv[bt]) begin
        streak[bt]++;
        if (streak[bt] == DB) begin
          nl[bt] = !lv[bt];
          streak[bt] = 0;
        end
      end else begin
        streak[bt] = 0;
      end
      fl[bt] = lv[bt] && !nl[bt];
      rs[bt] = !lv[bt] && nl[bt];
    end
    for (int m = 0; m < 2; m++) begin
      for (int bt = 0; bt < 2; bt++) begin
        k = ec - rise_e[m][bt] - 1;
        pend[bt] = !lk[m] && lv[bt] && !killed[m][bt] && !fl[bt] &&
                   (k == 0 ||
                    (m == 0 && k >= RD && (k - RD) % RP == 0));
      end
      for (int bt = 0; bt < 2; bt++) begin
        sup[bt] = pend[bt] && lv[1-bt];
        expp[m][bt] = pend[bt] && !sup[bt];
      end
      any_sup = sup[0] || sup[1];
      hit = lk[m] || any_sup;
      lk[m] = lk[m] ? (lv[0] || lv[1]) : any_sup;
      for (int bt = 0; bt < 2; bt++) begin
        if (hit || fl[bt]) killed[m][bt] = 1;
        if (rs[bt]) begin
          rise_e[m][bt] = ec;
          killed[m][bt] = 0;
        end
      end
    end
    lv[0] = nl[0];
    lv[1] = nl[1];
    ec++;
  endfunction

  int fa_cnt, ba_cnt, fb_cnt, bb_cnt;
  int fq [$];

  function automatic int qat(int i);
    return (fq.size() > i) ? fq[i] : -1000;
  endfunction

  task automatic clr_counts();
    fa_cnt = 0;
    ba_cnt = 0;
    fb_cnt = 0;
    bb_cnt = 0;
    fq.delete();
  endtask

  task automatic step(input bit f, input bit b, input bit r);
    fwd_raw = f;
    bwd_raw = b;
    reset = r;
    @(posedge clk);
    model_edge(f, b, r);
    #1;
    chk("rep_fwd", forward_a, expp[0][0]);
    chk("rep_bwd", backward_a, expp[0][1]);
    chk("rep_fheld", fwd_held_a, lv[0]);
    chk("rep_bheld", bwd_held_a, lv[1]);
    chk("rep_excl", forward_a & backward_a, 0);
    chk("one_fwd", forward_b, expp[1][0]);
    chk("one_bwd", backward_b, expp[1][1]);
    chk("one_fheld", fwd_held_b, lv[0]);
    chk("one_bheld", bwd_held_b, lv[1]);
    chk("one_excl", forward_b & backward_b, 0);
    if (forward_a === 1'b1) begin
      fa_cnt++;
      fq.push_back(ec - 1);
    end
    if (backward_a === 1'b1) ba_cnt++;
    if (forward_b === 1'b1) fb_cnt++;
    if (backward_b === 1'b1) bb_cnt++;
  endtask

  task automatic hold(input bit f, input bit b, input int n);
    for (int i = 0; i < n; i++) step(f, b, 1'b0);
  endtask

  initial begin
    int s;
    int r;
    int runf;
    int runb;
    bit f;
    bit b;

    fwd_raw = 1'b0;
    bwd_raw = 1'b0;
    reset = 1'b1;

    // reset with both buttons held
    step(1, 1, 1);
    step(1, 1, 1);
    step(0, 0, 1);
    chk("rst_fwd", forward_a, 0);
    chk("rst_fheld", fwd_held_a, 0);
    hold(0, 0, 8);

    // clean hold
    clr_counts();
    s = ec;
    hold(1, 0, 40);
    hold(0, 0, 20);
    chk("hold_p0", qat(0) - s, 6);
    chk("hold_p1", qat(1) - s, 16);
    chk("hold_p2", qat(2) - s, 19);
    chk("hold_p3", qat(3) - s, 22);
    chk("hold_bwd", ba_cnt, 0);
    chk("hold_one", fb_cnt, 1);

    // bounce then settle
    clr_counts();
    for (int i = 0; i < 20; i++) step(((i >> 1) & 1) == 0, 0, 0);
    chk("bnc_none", fa_cnt, 0);
    s = ec;
    hold(1, 0, 8);
    hold(0, 0, 20);
    chk("bnc_cnt", fa_cnt, 1);
    chk("bnc_p0", qat(0) - s, 6);

    // simultaneous press, staggered release, fresh press
    clr_counts();
    hold(1, 1, 20);
    hold(1, 0, 20);
    hold(0, 0, 15);
    chk("sim_f", fa_cnt, 0);
    chk("sim_b", ba_cnt, 0);
    s = ec;
    hold(1, 0, 8);
    hold(0, 0, 15);
    chk("sim_p0", qat(0) - s, 6);

    // second button pressed during a forward hold
    clr_counts();
    hold(1, 0, 8);
    hold(1, 1, 30);
    hold(1, 0, 10);
    hold(0, 0, 15);
    chk("int_f", fa_cnt, 1);
    chk("int_b", ba_cnt, 0);

    // reset in the middle of an auto-repeating hold
    clr_counts();
    hold(1, 0, 25);
    step(1, 0, 1);
    chk("mid_rst_f", forward_a, 0);
    chk("mid_rst_h", fwd_held_a, 0);
    r = ec - 1;
    fq.delete();
    hold(1, 0, 12);
    hold(0, 0, 15);
    chk("mid_p0", qat(0) - r, 7);
    chk("mid_one", fb_cnt, 2);

    // random runs on both buttons, occasional reset
    runf = 0;
    runb = 0;
    f = 0;
    b = 0;
    for (int i = 0; i < 600; i++) begin
      if (runf == 0) begin
        f = 1'($urandom_range(0, 1));
        runf = $urandom_range(1, 28);
      end
      if (runb == 0) begin
        b = 1'($urandom_range(0, 1));
        runb = $urandom_range(1, 28);
      end
      runf--;
      runb--;
      step(f, b, $urandom_range(0, 249) == 0);
    end
    hold(0, 0, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nav_button_conditioner.md
Name: nav_button_conditioner

Overview:
Conditions the two raw palette-navigation push-buttons into clean single-cycle forward/backward step pulses for the colour selector. The block sits directly upstream of the colour selector and drives its forward and backward inputs. Per button it provides:
- a 2-flop synchroniser
- a counter debouncer
- a rising-edge pulse generator
- hold-to-repeat

Arbitration between the buttons guarantees the two outputs are never asserted together.

Parameters:
DEBOUNCE_CYCLES  500000  consecutive stable synchronised samples needed to change the debounced state (10 ms at 50 MHz)
REPEAT_DELAY  25000000  cycles from the first pulse to the first auto-repeat pulse (500 ms)
REPEAT_PERIOD  5000000  cycles between subsequent auto-repeat pulses (100 ms)
REPEAT_EN  1  1 = hold-to-repeat enabled; 0 = one pulse per press

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
fwd_raw  input  1  raw forward button, active-high (inverted upstream), asynchronous to clk
bwd_raw  input  1  raw backward button, active-high, asynchronous to clk
forward  output  1  one-cycle step-forward pulse, registered
backward  output  1  one-cycle step-backward pulse, registered
fwd_held  output  1  debounced forward level, registered
bwd_held  output  1  debounced backward level, registered

Behaviour:
- Reset (synchronous, active-high, wins over all else):
  - Clears synchroniser flops, debounce counters, debounced levels, repeat counters and the lock.
  - Returns both FSMs to IDLE.
  - forward, backward, fwd_held and bwd_held read 0 the cycle after reset is sampled.
- Synchroniser: 2 flops per input. The raw value sampled at edge k appears at the sync output after edge k+1.
- Debounce:
  - The counter increments while the sync output differs from the debounced level.
  - Any mismatch-free cycle clears the counter to 0.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Latency: raw first high at edge 0 with no bounce gives a debounced rise after edge DEBOUNCE_CYCLES+1 and the output pulse during the cycle after edge DEBOUNCE_CYCLES+2.
- Per-button FSM:
  - IDLE: on debounced rise, issue a pulse and go to WAIT.
  - WAIT: count REPEAT_DELAY cycles from the pulse edge. On expiry, issue a pulse and go to REPEAT (only if REPEAT_EN=1; otherwise stay in WAIT).
  - REPEAT: issue a pulse every REPEAT_PERIOD cycles.
  - On debounced fall in any state, return to IDLE immediately. No pulse is issued on or after the edge at which the debounced level falls.
- Pulse width is exactly 1 cycle. Repeat counters are sized from max(REPEAT_DELAY, REPEAT_PERIOD).
- Arbitration / lock:
  - A pending pulse is suppressed if the other button's debounced level is high in the same cycle.
  - This includes both debounced levels rising on the same edge.
  - Any suppression sets lock, which forces both FSMs to IDLE and blocks all pulses.
  - lock clears only when both debounced levels are low.
  - Invariant: forward & backward is never 1.
- Reset released while a button is still physically held: treated as a new press, giving a pulse DEBOUNCE_CYCLES+2 edges after the first post-reset sample.
- Bounce: any sync toggle restarts the debounce count, so only one pulse is produced per settled press.
- Outputs are never combinational from inputs.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1. Edge 0 = first edge sampling the stimulus.
- Reset: assert reset 2 cycles with fwd_raw=bwd_raw=1 -> all outputs 0 during and the cycle after reset.
- Clean hold: fwd_raw=1 for edges 0..39 -> forward pulses exactly at edges 6, 16, 19, 22, 25, ...; backward stays 0; fwd_held rises at edge 5; no forward pulse at or after the edge fwd_held falls.
- Bounce: fwd_raw toggles every 2 cycles for 20 cycles, then stays high from edge S -> exactly one forward pulse, at edge S+6.
- Simultaneous press: fwd_raw and bwd_raw rise together -> no pulses at all. Then release bwd_raw while forward is still held -> still no pulse. Release both, wait for held levels to fall, press fwd_raw again -> forward pulse 6 edges later.
- Second-button interference: hold fwd_raw until the edge-6 pulse, then press bwd_raw -> no further forward pulses and no backward pulse; lock persists until both are released.
- Reset mid-hold: fwd_raw held and in REPEAT, reset pulsed 1 cycle -> outputs 0; next forward pulse 6 edges after reset deasserts; REPEAT_EN=0 variant shows a single pulse per press.
